// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the 2-read / 1-write register file.
package reg_file_pkg;

  // Sweep state: CLEAR zeroes the array one word per cycle, READY serves accesses.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Address width for a given depth; never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: range check, write-first bypass, data/valid
// registers and a combinational out-of-range flag for the shared AddrErr.
module reg_file_rd_port import reg_file_pkg::*; #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  mem_word,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              err
);

  logic in_range;
  logic hit;
  logic take;

  // Compare at 32 bits so a power-of-two depth does not collapse to a constant.
  assign in_range = 32'(rd_addr) < DEPTH;
  // wr_en is only high for a write that will actually commit this edge.
  assign hit      = wr_en && (wr_addr == rd_addr);
  assign take     = active && rd_en;
  assign err      = take && !in_range;

  // Capture read data (bypass wins over storage); data holds when no read is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= take;
      if (take)
        rd_data <= !in_range ? '0 : (hit ? wr_data : mem_word);
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// Parametrised register file: one write port, two registered read ports,
// write-first bypass, out-of-range flagging and a self-clearing sweep.
module reg_file_2r1w import reg_file_pkg::*; #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [WIDTH-1:0]  WrData,
  input  logic              RdEn0,
  input  logic [ADDR_W-1:0] RdAddr0,
  input  logic              RdEn1,
  input  logic [ADDR_W-1:0] RdAddr1,
  input  logic              ClrReq,
  output logic [WIDTH-1:0]  RdData0,
  output logic              RdValid0,
  output logic [WIDTH-1:0]  RdData1,
  output logic              RdValid1,
  output logic              Busy,
  output logic              AddrErr
);

  localparam int NUM_RD = 2;

  state_t                          state, state_nx;
  logic [ADDR_W-1:0]               clr_ptr;
  logic [WIDTH-1:0]                mem [DEPTH];
  logic                            active, clr_last;
  logic                            wr_in_range, wr_commit, wr_err;

  logic [NUM_RD-1:0]               rd_en;
  logic [NUM_RD-1:0][ADDR_W-1:0]   rd_addr;
  logic [NUM_RD-1:0][WIDTH-1:0]    rd_word;
  logic [NUM_RD-1:0][WIDTH-1:0]    rd_data;
  logic [NUM_RD-1:0]               rd_valid;
  logic [NUM_RD-1:0]               rd_err;

  assign active      = (state == READY);
  assign Busy        = !active;
  assign clr_last    = (clr_ptr == ADDR_W'(DEPTH - 1));
  assign wr_in_range = 32'(WrAddr) < DEPTH;
  // A ClrReq cycle drops the write, so it neither commits nor bypasses.
  assign wr_commit   = active && WrEn && !ClrReq && wr_in_range;
  assign wr_err      = active && WrEn && !ClrReq && !wr_in_range;

  assign rd_en   = {RdEn1, RdEn0};
  assign rd_addr = {RdAddr1, RdAddr0};

  // State register; reset always (re)starts the sweep.
  always_ff @(posedge CLK) begin
    if (RST) state <= CLEAR;
    else     state <= state_nx;
  end

  // Next state: sweep ends after the last word, ClrReq only honoured in READY.
  always_comb begin
    state_nx = state;
    case (state)
      CLEAR:   if (clr_last) state_nx = READY;
      READY:   if (ClrReq)   state_nx = CLEAR;
      default: state_nx = CLEAR;
    endcase
  end

  // Sweep pointer: zeroed on reset or a new request, advances while clearing.
  always_ff @(posedge CLK) begin
    if (RST || (active && ClrReq))
      clr_ptr <= '0;
    else if (!active)
      clr_ptr <= clr_last ? '0 : clr_ptr + 1'b1;
  end

  // Storage: sweep writes zeros, otherwise a committed write updates one word.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (!active)
        mem[clr_ptr] <= '0;
      else if (wr_commit)
        mem[WrAddr] <= WrData;
    end
  end

  // One pulse per cycle if any accepted access was out of range.
  always_ff @(posedge CLK) begin
    if (RST) AddrErr <= 1'b0;
    else     AddrErr <= wr_err || (|rd_err);
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign rd_word[p] = mem[rd_addr[p]];

    reg_file_rd_port #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_port (
      .clk      (CLK),
      .rst      (RST),
      .active   (active),
      .rd_en    (rd_en[p]),
      .rd_addr  (rd_addr[p]),
      .mem_word (rd_word[p]),
      .wr_en    (wr_commit),
      .wr_addr  (WrAddr),
      .wr_data  (WrData),
      .rd_data  (rd_data[p]),
      .rd_valid (rd_valid[p]),
      .err      (rd_err[p])
    );
  end

  assign RdData0  = rd_data[0];
  assign RdValid0 = rd_valid[0];
  assign RdData1  = rd_data[1];
  assign RdValid1 = rd_valid[1];

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: a DEPTH=16 and a DEPTH=10 instance share stimulus;
// a behavioural model per instance feeds a scoreboard, plus a vector table
// and hand sequences for sweeps, reset mid-sweep and out-of-range accesses.
module tb_reg_file_2r1w;

  logic        clk = 1'b0;
  logic        rst, wr_en, rd_en0, rd_en1, clr;
  logic [3:0]  wr_addr, rd_addr0, rd_addr1;
  logic [15:0] wr_data;

  logic [15:0] rd_data0_a, rd_data1_a, rd_data0_b, rd_data1_b;
  logic        rd_valid0_a, rd_valid1_a, busy_a, addr_err_a;
  logic        rd_valid0_b, rd_valid1_b, busy_b, addr_err_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_file_2r1w #(.WIDTH(16), .DEPTH(16)) dut_a (
    .CLK(clk), .RST(rst), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data),
    .RdEn0(rd_en0), .RdAddr0(rd_addr0), .RdEn1(rd_en1), .RdAddr1(rd_addr1),
    .ClrReq(clr), .RdData0(rd_data0_a), .RdValid0(rd_valid0_a),
    .RdData1(rd_data1_a), .RdValid1(rd_valid1_a), .Busy(busy_a), .AddrErr(addr_err_a)
  );

  reg_file_2r1w #(.WIDTH(16), .DEPTH(10)) dut_b (
    .CLK(clk), .RST(rst), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data),
    .RdEn0(rd_en0), .RdAddr0(rd_addr0), .RdEn1(rd_en1), .RdAddr1(rd_addr1),
    .ClrReq(clr), .RdData0(rd_data0_b), .RdValid0(rd_valid0_b),
    .RdData1(rd_data1_b), .RdValid1(rd_valid1_b), .Busy(busy_b), .AddrErr(addr_err_b)
  );

  typedef struct packed {
    logic [15:0] d0;
    logic        v0;
    logic [15:0] d1;
    logic        v1;
    logic        err;
    logic        busy;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // Behavioural model state, index 0 = dut_a, 1 = dut_b.
  logic [15:0] m_mem [2][16];
  logic [15:0] m_rd0 [2];
  logic [15:0] m_rd1 [2];
  int          busy_left [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict outputs after the coming edge from the current inputs.
  task automatic model();
    for (int i = 0; i < 2; i++) begin
      int   d;
      exp_t e;
      logic wok;
      d      = (i == 0) ? 16 : 10;
      e.d0   = m_rd0[i];
      e.d1   = m_rd1[i];
      e.v0   = 1'b0;
      e.v1   = 1'b0;
      e.err  = 1'b0;
      if (rst) begin
        busy_left[i] = d;
        e.d0 = '0;
        e.d1 = '0;
        for (int a = 0; a < 16; a++) m_mem[i][a] = '0;
      end else if (busy_left[i] > 0) begin
        busy_left[i]--;
      end else begin
        wok = wr_en && !clr && (int'(wr_addr) < d);
        if (rd_en0) begin
          e.v0 = 1'b1;
          e.d0 = (int'(rd_addr0) >= d) ? 16'h0 :
                 (wok && wr_addr == rd_addr0) ? wr_data : m_mem[i][rd_addr0];
        end
        if (rd_en1) begin
          e.v1 = 1'b1;
          e.d1 = (int'(rd_addr1) >= d) ? 16'h0 :
                 (wok && wr_addr == rd_addr1) ? wr_data : m_mem[i][rd_addr1];
        end
        e.err = (wr_en && !clr && int'(wr_addr) >= d) ||
                (rd_en0 && int'(rd_addr0) >= d) || (rd_en1 && int'(rd_addr1) >= d);
        if (wok) m_mem[i][wr_addr] = wr_data;
        if (clr) begin
          busy_left[i] = d;
          for (int a = 0; a < 16; a++) m_mem[i][a] = '0;
        end
      end
      e.busy   = (busy_left[i] > 0);
      m_rd0[i] = e.d0;
      m_rd1[i] = e.d1;
      if (i == 0) qa.push_back(e);
      else        qb.push_back(e);
    end
  endtask

  task automatic sb_check();
    exp_t e;
    if (qa.size() == 0 || qb.size() == 0) begin
      chk("sb_empty", 64'(qa.size()), 64'(1));
    end else begin
      e = qa.pop_front();
      chk("sb_a", 64'({rd_data0_a, rd_valid0_a, rd_data1_a, rd_valid1_a, addr_err_a, busy_a}), 64'(e));
      e = qb.pop_front();
      chk("sb_b", 64'({rd_data0_b, rd_valid0_b, rd_data1_b, rd_valid1_b, addr_err_b, busy_b}), 64'(e));
    end
  endtask

  // One clock: push prediction, take the edge, compare just after it.
  task automatic step();
    model();
    @(posedge clk);
    #1;
    sb_check();
  endtask

  task automatic idle();
    rst = 0; wr_en = 0; rd_en0 = 0; rd_en1 = 0; clr = 0;
    wr_addr = 0; rd_addr0 = 0; rd_addr1 = 0; wr_data = 0;
  endtask

  // Count cycles dut_a stays busy (bounded); ClrReq optionally pulsed early in the sweep.
  task automatic count_busy(input bit poke_clr, output int n);
    n = 0;
    while (busy_a && n < 100) begin
      clr = poke_clr && (n < 4);
      step();
      n++;
    end
    clr = 0;
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) begin
      rd_en0 = 1; rd_addr0 = 4'(a);
      rd_en1 = 1; rd_addr1 = 4'(15 - a);
      step();
    end
    rd_en0 = 0; rd_en1 = 0;
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        re0;
    logic [3:0]  ra0;
    logic        re1;
    logic [3:0]  ra1;
    logic [15:0] d0;
    logic        v0;
    logic [15:0] d1;
    logic        v1;
  } vec_t;

  vec_t vt[10];
  int   n;

  initial begin
    // inputs                                   expected on dut_a
    vt[0] = '{1'b1, 4'd1,  16'h0003, 1'b0, 4'd0,  1'b0, 4'd0,  16'h0000, 1'b0, 16'h0000, 1'b0};
    vt[1] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd1,  1'b0, 4'd0,  16'h0003, 1'b1, 16'h0000, 1'b0};
    vt[2] = '{1'b0, 4'd1,  16'h0005, 1'b0, 4'd1,  1'b0, 4'd0,  16'h0003, 1'b0, 16'h0000, 1'b0};
    vt[3] = '{1'b1, 4'd3,  16'h0007, 1'b0, 4'd0,  1'b0, 4'd0,  16'h0003, 1'b0, 16'h0000, 1'b0};
    vt[4] = '{1'b1, 4'd3,  16'h00AA, 1'b1, 4'd3,  1'b1, 4'd3,  16'h00AA, 1'b1, 16'h00AA, 1'b1};
    vt[5] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd3,  1'b1, 4'd1,  16'h00AA, 1'b1, 16'h0003, 1'b1};
    vt[6] = '{1'b1, 4'd15, 16'hBEEF, 1'b0, 4'd0,  1'b1, 4'd15, 16'h00AA, 1'b0, 16'hBEEF, 1'b1};
    vt[7] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd15, 1'b1, 4'd15, 16'hBEEF, 1'b1, 16'hBEEF, 1'b1};
    vt[8] = '{1'b1, 4'd0,  16'h1111, 1'b1, 4'd0,  1'b1, 4'd3,  16'h1111, 1'b1, 16'h00AA, 1'b1};
    vt[9] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd2,  1'b0, 4'd0,  16'h0000, 1'b1, 16'h00AA, 1'b0};

    // Reset state and initial sweep.
    idle();
    rst = 1;
    step();
    chk("rst_state", 64'({busy_a, rd_valid0_a, rd_valid1_a, addr_err_a, rd_data0_a}), 64'({4'b1000, 16'h0}));
    rst = 0;
    count_busy(1'b0, n);
    chk("rst_sweep_len", 64'(n), 64'(16));
    read_all();

    // Vector table: write/read, hold, dual read, bypass.
    for (int i = 0; i < 10; i++) begin
      wr_en = vt[i].we;  wr_addr = vt[i].wa;  wr_data = vt[i].wd;
      rd_en0 = vt[i].re0; rd_addr0 = vt[i].ra0;
      rd_en1 = vt[i].re1; rd_addr1 = vt[i].ra1;
      step();
      chk($sformatf("vec%0d", i),
          64'({rd_data0_a, rd_valid0_a, rd_data1_a, rd_valid1_a}),
          64'({vt[i].d0, vt[i].v0, vt[i].d1, vt[i].v1}));
    end
    idle();

    // Out-of-range on the DEPTH=10 instance.
    wr_en = 1; wr_addr = 4'd12; wr_data = 16'h1234;
    step();
    chk("oor_wr_err", 64'(addr_err_b), 64'(1));
    idle();
    step();
    chk("oor_err_pulse", 64'(addr_err_b), 64'(0));
    rd_en0 = 1; rd_addr0 = 4'd12;
    step();
    chk("oor_rd", 64'({rd_data0_b, rd_valid0_b, addr_err_b}), 64'({16'h0, 1'b1, 1'b1}));
    idle();

    // Clear request with full array; writes during the sweep are dropped.
    for (int a = 0; a < 16; a++) begin
      wr_en = 1; wr_addr = 4'(a); wr_data = 16'hFFFF;
      step();
    end
    wr_en = 0;
    clr = 1;
    step();
    chk("clr_busy", 64'(busy_a), 64'(1));
    wr_en = 1; wr_addr = 4'd5; wr_data = 16'h5555;
    count_busy(1'b1, n);
    chk("clr_sweep_len", 64'(n), 64'(16));
    idle();
    read_all();
    rd_en0 = 1; rd_addr0 = 4'd5;
    step();
    chk("clr_drop_wr", 64'({rd_data0_a, rd_valid0_a}), 64'({16'h0, 1'b1}));
    idle();

    // Reset in the middle of a sweep restarts it.
    rst = 1;
    step();
    rst = 0;
    for (int c = 0; c < 5; c++) step();
    rst = 1;
    step();
    rst = 0;
    count_busy(1'b1, n);
    chk("rst_mid_sweep_len", 64'(n), 64'(16));

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 149) == 0);
      clr      = ($urandom_range(0, 39) == 0);
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = 4'($urandom_range(0, 15));
      wr_data  = 16'($urandom);
      rd_en0   = 1'($urandom_range(0, 1));
      rd_addr0 = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      rd_en1   = 1'($urandom_range(0, 1));
      rd_addr1 = ($urandom_range(0, 3) == 0) ? rd_addr0 : 4'($urandom_range(0, 15));
      step();
    end
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
